// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared fetch/decode types and default widths
package proc_pkg;

   localparam int XLEN               = 32;
   localparam int DEFAULT_ADDR_WIDTH = 32;
   localparam int INSTR_BYTES        = XLEN / 8;

   // Handed from ins_fetch to ins_dec.
   typedef struct packed {
      logic [DEFAULT_ADDR_WIDTH-1:0] pc;
      logic [XLEN-1:0]               instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_RESET_WAIT,
      ST_RUN,
      ST_DRAIN
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - parameterised synchronous FIFO with flush and occupancy count
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is only taken when a pop frees the slot.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - instruction fetch stage: PC, credit-limited requests, response FIFO, redirect flush
module ins_fetch
   import proc_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = XLEN,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    DEPTH      = 2
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
   input  logic                  mem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
   output logic                  ins_valid_o,
   input  logic                  ins_ready_i,
   output logic [DATA_WIDTH-1:0] ins_data_o,
   output logic [ADDR_WIDTH-1:0] ins_pc_o,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFS   = $clog2(BYTES);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SW    = CW + 2;

   fetch_state_t          state, state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic [CW-1:0]         outstanding, outstanding_next;
   logic [CW-1:0]         discard, discard_next;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [SW-1:0]         credit_used;
   logic                  req_fire;
   logic                  rsp_keep;
   logic [ADDR_WIDTH-1:0] rsp_pc;
   logic [ADDR_WIDTH-1:0] redirect_target;

   assign credit_used     = SW'(outstanding) + SW'(fifo_count) + SW'(discard);
   assign req_fire        = mem_req_valid_o && mem_req_ready_i;
   assign rsp_keep        = mem_rsp_valid_i && (discard == '0);
   assign redirect_target = redirect_pc_i & ~ADDR_WIDTH'(BYTES - 1);
   // Requests are sequential since the last redirect, so the oldest counted one sits 'outstanding' words behind pc.
   assign rsp_pc          = pc - (ADDR_WIDTH'(outstanding) << OFS);
   assign mem_req_addr_o  = pc;

   assign fifo_push   = rsp_keep && !redirect_i;
   assign fifo_pop    = ins_ready_i && !redirect_i;
   assign ins_valid_o = !fifo_empty;

   always_comb begin
      state_next       = state;
      discard_next     = discard;
      outstanding_next = outstanding;
      mem_req_valid_o  = (state != ST_RESET_WAIT) && !redirect_i && (credit_used < SW'(DEPTH));
      if (redirect_i) begin
         // Everything still in flight becomes stale, less any response landing right now.
         discard_next     = discard + outstanding - CW'(mem_rsp_valid_i);
         outstanding_next = '0;
      end else begin
         if (mem_rsp_valid_i && discard != '0) discard_next = discard - CW'(1);
         outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_keep);
      end
      unique case (state)
         ST_RESET_WAIT:     state_next = ST_RUN;
         ST_RUN, ST_DRAIN:  state_next = (discard_next != '0) ? ST_DRAIN : ST_RUN;
         default:           state_next = ST_RESET_WAIT;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state       <= ST_RESET_WAIT;
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         state       <= state_next;
         outstanding <= outstanding_next;
         discard     <= discard_next;
         if (redirect_i)    pc <= redirect_target;
         else if (req_fire) pc <= pc + ADDR_WIDTH'(BYTES);
      end
   end

   fetch_fifo #(
      .WIDTH(ADDR_WIDTH + DATA_WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (arst_i),
      .push  (fifo_push),
      .wdata ({rsp_pc, mem_rsp_data_i}),
      .pop   (fifo_pop),
      .flush (redirect_i),
      .rdata ({ins_pc_o, ins_data_o}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifndef SYNTHESIS
   initial begin
      if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0)
         $fatal(1, "ins_fetch: DATA_WIDTH must be a power of 2 and >= 8");
      if (DEPTH < 1)
         $fatal(1, "ins_fetch: DEPTH must be >= 1");
      if ((RESET_PC & ADDR_WIDTH'(BYTES - 1)) != '0)
         $fatal(1, "ins_fetch: RESET_PC not word aligned");
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (arst_i)
      !(fifo_push && fifo_full && !(fifo_pop && !fifo_empty)))
      else $error("ins_fetch: FIFO push while full");

   a_rsp_expected: assert property (@(posedge clk_i) disable iff (arst_i)
      !(mem_rsp_valid_i && outstanding == '0 && discard == '0))
      else $error("ins_fetch: response with nothing in flight");
`endif

endmodule
